// File: rtl/ddr_ui_line_adapter.sv
// Cache-line request/response channel to DDR controller app_* user interface.
// One transaction in flight; also flags protocol errors and watchdog timeouts.
module ddr_ui_line_adapter #(
  parameter int unsigned ui_addr_width_p   = 28,
  parameter int unsigned ui_data_width_p   = 64,
  parameter int unsigned ui_burst_length_p = 8,
  parameter int unsigned timeout_cycles_p  = 4096
) (
  input  logic                                                  ui_clk_i,
  input  logic                                                  ui_reset_i,
  input  logic                                                  init_calib_complete_i,
  input  logic                                                  req_valid_i,
  output logic                                                  req_ready_o,
  input  logic                                                  req_write_i,
  input  logic [ui_addr_width_p-1:0]                            req_addr_i,
  input  logic [ui_data_width_p*ui_burst_length_p-1:0]          req_wdata_i,
  input  logic [(ui_data_width_p/8)*ui_burst_length_p-1:0]      req_wmask_i,
  output logic                                                  rsp_valid_o,
  input  logic                                                  rsp_ready_i,
  output logic                                                  rsp_write_o,
  output logic [ui_data_width_p*ui_burst_length_p-1:0]          rsp_rdata_o,
  output logic [ui_addr_width_p-1:0]                            app_addr_o,
  output logic [2:0]                                            app_cmd_o,
  output logic                                                  app_en_o,
  input  logic                                                  app_rdy_i,
  output logic [ui_data_width_p-1:0]                            app_wdf_data_o,
  output logic [ui_data_width_p/8-1:0]                          app_wdf_mask_o,
  output logic                                                  app_wdf_wren_o,
  output logic                                                  app_wdf_end_o,
  input  logic                                                  app_wdf_rdy_i,
  input  logic [ui_data_width_p-1:0]                            app_rd_data_i,
  input  logic                                                  app_rd_data_valid_i,
  input  logic                                                  app_rd_data_end_i,
  output logic                                                  err_o,
  output logic                                                  busy_o
);

  localparam int unsigned line_w_lp = ui_data_width_p * ui_burst_length_p;
  localparam int unsigned mask_w_lp = ui_data_width_p / 8;
  localparam int unsigned lb_lp     = $clog2(line_w_lp / 8);
  localparam int unsigned kw_lp     = $clog2(ui_burst_length_p);

  localparam logic [ui_addr_width_p-1:0] low_mask_lp = ui_addr_width_p'((64'd1 << lb_lp) - 64'd1);
  localparam logic [kw_lp-1:0]           k_last_lp   = kw_lp'(ui_burst_length_p - 1);
  localparam logic [15:0]                wd_last_lp  = 16'(timeout_cycles_p - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WR   = 2'd1;
  localparam logic [1:0] RD   = 2'd2;
  localparam logic [1:0] RSP  = 2'd3;

  logic [1:0]                           state;
  logic [kw_lp-1:0]                     k;
  logic                                 cmd_done;
  logic                                 data_done;
  logic                                 write_q;
  logic                                 err_q;
  logic [15:0]                          wd;
  logic [ui_addr_width_p-1:0]           addr_q;
  logic [line_w_lp-1:0]                 wdata_q;
  logic [mask_w_lp*ui_burst_length_p-1:0] wmask_q;
  logic [line_w_lp-1:0]                 rdata_q;

  logic xfer;
  logic cmd_fire;
  logic beat_fire;
  logic k_last;

  assign xfer        = (state == WR) || (state == RD);
  assign req_ready_o = (state == IDLE) && init_calib_complete_i && !ui_reset_i;
  assign app_en_o    = xfer && !cmd_done;
  assign app_cmd_o   = (state == RD) ? 3'b001 : 3'b000;
  assign app_addr_o  = addr_q;

  assign app_wdf_wren_o = (state == WR) && !data_done;
  assign app_wdf_data_o = wdata_q[k*ui_data_width_p +: ui_data_width_p];
  assign app_wdf_mask_o = wmask_q[k*mask_w_lp +: mask_w_lp];
  assign k_last         = (k == k_last_lp);
  assign app_wdf_end_o  = app_wdf_wren_o && k_last;

  assign cmd_fire  = app_en_o && app_rdy_i;
  assign beat_fire = app_wdf_wren_o && app_wdf_rdy_i;

  assign rsp_valid_o = (state == RSP);
  assign rsp_write_o = (state == RSP) && write_q;
  assign rsp_rdata_o = rdata_q;
  assign busy_o      = (state != IDLE);
  assign err_o       = err_q;

  always_ff @(posedge ui_clk_i) begin
    if (ui_reset_i) begin
      state     <= IDLE;
      k         <= '0;
      cmd_done  <= 1'b0;
      data_done <= 1'b0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      wd        <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      rdata_q   <= '0;
    end else begin
      if (app_rd_data_valid_i && (state != RD)) err_q <= 1'b1;

      // Watchdog saturates; hitting the limit only flags, the transfer continues.
      if (xfer) begin
        if (wd != '1) wd <= wd + 16'd1;
        if (wd == wd_last_lp) err_q <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (req_valid_i && req_ready_o) begin
            addr_q    <= req_addr_i & ~low_mask_lp;
            wdata_q   <= req_wdata_i;
            wmask_q   <= req_wmask_i;
            write_q   <= req_write_i;
            k         <= '0;
            cmd_done  <= 1'b0;
            data_done <= 1'b0;
            wd        <= '0;
            state     <= req_write_i ? WR : RD;
          end
        end
        WR: begin
          if (cmd_fire) cmd_done <= 1'b1;
          if (beat_fire) begin
            k <= k + 1'b1;
            if (k_last) data_done <= 1'b1;
          end
          if ((cmd_done || cmd_fire) && (data_done || (beat_fire && k_last))) state <= RSP;
        end
        RD: begin
          if (cmd_fire) cmd_done <= 1'b1;
          if (app_rd_data_valid_i) begin
            rdata_q[k*ui_data_width_p +: ui_data_width_p] <= app_rd_data_i;
            k <= k + 1'b1;
            if (app_rd_data_end_i != k_last) err_q <= 1'b1;
            if (k_last) state <= RSP;
          end
        end
        default: begin
          if (rsp_ready_i) begin
            state <= IDLE;
            k     <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_ui_line_adapter.sv
// Directed bench for ddr_ui_line_adapter: transaction-level model compared every
// cycle, plus hand-computed literal checks for each scenario.
module tb_ddr_ui_line_adapter;

  localparam int unsigned A  = 28;
  localparam int unsigned W  = 64;
  localparam int unsigned BL = 8;
  localparam int unsigned T  = 16;

  logic            clk = 1'b0;
  logic            ui_reset_i = 1'b1;
  logic            calib = 1'b0;
  logic            req_valid_i = 1'b0;
  logic            req_ready_o;
  logic            req_write_i = 1'b0;
  logic [A-1:0]    req_addr_i = '0;
  logic [511:0]    req_wdata_i = '0;
  logic [63:0]     req_wmask_i = '0;
  logic            rsp_valid_o;
  logic            rsp_ready_i = 1'b0;
  logic            rsp_write_o;
  logic [511:0]    rsp_rdata_o;
  logic [A-1:0]    app_addr_o;
  logic [2:0]      app_cmd_o;
  logic            app_en_o;
  logic            app_rdy_i = 1'b0;
  logic [63:0]     app_wdf_data_o;
  logic [7:0]      app_wdf_mask_o;
  logic            app_wdf_wren_o;
  logic            app_wdf_end_o;
  logic            app_wdf_rdy_i = 1'b0;
  logic [63:0]     app_rd_data_i = '0;
  logic            app_rd_data_valid_i = 1'b0;
  logic            app_rd_data_end_i = 1'b0;
  logic            err_o;
  logic            busy_o;

  int checks = 0;
  int failures = 0;

  ddr_ui_line_adapter #(
    .ui_addr_width_p(A),
    .ui_data_width_p(W),
    .ui_burst_length_p(BL),
    .timeout_cycles_p(T)
  ) dut (
    .ui_clk_i(clk),
    .ui_reset_i(ui_reset_i),
    .init_calib_complete_i(calib),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_write_i(req_write_i),
    .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i),
    .req_wmask_i(req_wmask_i),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_write_o(rsp_write_o),
    .rsp_rdata_o(rsp_rdata_o),
    .app_addr_o(app_addr_o),
    .app_cmd_o(app_cmd_o),
    .app_en_o(app_en_o),
    .app_rdy_i(app_rdy_i),
    .app_wdf_data_o(app_wdf_data_o),
    .app_wdf_mask_o(app_wdf_mask_o),
    .app_wdf_wren_o(app_wdf_wren_o),
    .app_wdf_end_o(app_wdf_end_o),
    .app_wdf_rdy_i(app_wdf_rdy_i),
    .app_rd_data_i(app_rd_data_i),
    .app_rd_data_valid_i(app_rd_data_valid_i),
    .app_rd_data_end_i(app_rd_data_end_i),
    .err_o(err_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Transaction-level model: pending command, queue of beats still to send,
  // beats received so far, response pending, sticky error, cycles in transfer.
  bit          m_active, m_rsp, m_write, m_cmd_seen, m_err;
  logic [A-1:0] m_addr;
  logic [63:0] wq_data[$];
  logic [7:0]  wq_mask[$];
  logic [63:0] rq[$];
  logic [511:0] m_rline;
  int unsigned m_wd;

  always @(negedge clk) begin
    if (ui_reset_i) begin
      m_active = 0; m_rsp = 0; m_write = 0; m_cmd_seen = 0; m_err = 0;
      m_addr = '0; m_rline = '0; m_wd = 0;
      wq_data.delete(); wq_mask.delete(); rq.delete();
    end else begin
      bit in_read;
      chk("req_ready", req_ready_o, !m_active && !m_rsp && calib);
      chk("busy", busy_o, m_active || m_rsp);
      chk("app_en", app_en_o, m_active && !m_cmd_seen);
      if (m_active && !m_cmd_seen) begin
        chk("app_addr", app_addr_o, m_addr);
        chk("app_cmd", app_cmd_o, m_write ? 3'b000 : 3'b001);
      end
      chk("wdf_wren", app_wdf_wren_o, m_active && m_write && (wq_data.size() > 0));
      if (m_active && m_write && (wq_data.size() > 0)) begin
        chk("wdf_data", app_wdf_data_o, wq_data[0]);
        chk("wdf_mask", app_wdf_mask_o, wq_mask[0]);
        chk("wdf_end", app_wdf_end_o, wq_data.size() == 1);
      end else begin
        chk("wdf_end_idle", app_wdf_end_o, 1'b0);
      end
      chk("rsp_valid", rsp_valid_o, m_rsp);
      if (m_rsp) begin
        chk("rsp_write", rsp_write_o, m_write);
        if (!m_write) chk("rsp_rdata", rsp_rdata_o, m_rline);
      end
      chk("err", err_o, m_err);

      in_read = m_active && !m_write;
      if (app_rd_data_valid_i && !in_read) m_err = 1;
      if (!m_active && !m_rsp) begin
        if (req_valid_i && calib) begin
          m_active = 1; m_write = req_write_i; m_cmd_seen = 0; m_wd = 0;
          m_addr = req_addr_i & ~28'h3f;
          wq_data.delete(); wq_mask.delete(); rq.delete();
          if (req_write_i)
            for (int i = 0; i < BL; i++) begin
              wq_data.push_back(req_wdata_i[i*W +: W]);
              wq_mask.push_back(req_wmask_i[i*8 +: 8]);
            end
        end
      end else if (m_active) begin
        if (m_wd < 65535) m_wd++;
        if (m_wd == T) m_err = 1;
        if (!m_cmd_seen && app_rdy_i) m_cmd_seen = 1;
        if (m_write) begin
          if (wq_data.size() > 0 && app_wdf_rdy_i) begin
            void'(wq_data.pop_front());
            void'(wq_mask.pop_front());
          end
          if (m_cmd_seen && wq_data.size() == 0) begin m_active = 0; m_rsp = 1; end
        end else if (app_rd_data_valid_i) begin
          if (app_rd_data_end_i != (rq.size() == BL - 1)) m_err = 1;
          rq.push_back(app_rd_data_i);
          if (rq.size() == BL) begin
            for (int i = 0; i < BL; i++) m_rline[i*W +: W] = rq[i];
            m_active = 0; m_rsp = 1;
          end
        end
      end else if (rsp_ready_i) begin
        m_rsp = 0;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int budget);
    int n = 0;
    while (!rsp_valid_o && n < budget) begin tick(); n++; end
    chk("rsp_wait", rsp_valid_o, 1'b1);
  endtask

  task automatic rsp_handshake;
    rsp_ready_i = 1; tick(); rsp_ready_i = 0;
  endtask

  task automatic do_reset;
    ui_reset_i = 1; tick(); tick(); ui_reset_i = 0; tick();
  endtask

  task automatic send_read(input logic [A-1:0] addr);
    int n = 0;
    req_valid_i = 1; req_write_i = 0; req_addr_i = addr;
    while (!req_ready_o && n < 20) begin tick(); n++; end
    chk("req_accept", req_ready_o, 1'b1);
    tick();
    req_valid_i = 0;
  endtask

  task automatic rd_beat(input logic [63:0] d, input logic e);
    app_rd_data_valid_i = 1; app_rd_data_i = d; app_rd_data_end_i = e;
    tick();
    app_rd_data_valid_i = 0; app_rd_data_end_i = 0;
  endtask

  initial begin
    logic [511:0] exp_line;
    int beats, ends, end_idx, first_err;

    // 1/2: calibration gating, then a write with everything ready
    req_valid_i = 1; req_write_i = 1; req_addr_i = 28'h0012345;
    for (int i = 0; i < BL; i++) begin
      req_wdata_i[i*W +: W] = 64'hC0DE_0000_0000_0000 + 64'(i * 257);
      req_wmask_i[i*8 +: 8] = 8'hFF >> i;
    end
    tick(); tick();
    ui_reset_i = 0;
    tick(); tick();
    chk("t1_ready_no_calib", req_ready_o, 1'b0);
    chk("t1_no_app_en", app_en_o, 1'b0);
    calib = 1; #1;
    chk("t1_ready_calib", req_ready_o, 1'b1);
    tick();
    req_valid_i = 0;
    chk("t1_app_en_latency", app_en_o, 1'b1);
    chk("t2_addr", app_addr_o, 28'h0012340);
    chk("t2_cmd", app_cmd_o, 3'b000);
    app_rdy_i = 1; app_wdf_rdy_i = 1;
    beats = 0; ends = 0; end_idx = -1;
    for (int c = 0; c < 30 && !rsp_valid_o; c++) begin
      if (app_wdf_wren_o) begin
        if (app_wdf_end_o) begin ends++; end_idx = beats; end
        beats++;
      end
      tick();
    end
    chk("t2_beats", beats, 8);
    chk("t2_end_count", ends, 1);
    chk("t2_end_beat", end_idx, 7);
    chk("t2_rsp_valid", rsp_valid_o, 1'b1);
    chk("t2_rsp_write", rsp_write_o, 1'b1);
    app_rdy_i = 0; app_wdf_rdy_i = 0;

    // next request waits through the response handshake cycle
    req_valid_i = 1; req_write_i = 1; req_addr_i = 28'h0ABCDEF;
    for (int i = 0; i < BL; i++) begin
      req_wdata_i[i*W +: W] = 64'h5A5A_0000_0000_0000 ^ 64'(i * 4099);
      req_wmask_i[i*8 +: 8] = 8'h01 << i;
    end
    rsp_ready_i = 1; #1;
    chk("t2_no_b2b_accept", req_ready_o, 1'b0);
    tick();
    rsp_ready_i = 0;
    chk("t3_ready_after_rsp", req_ready_o, 1'b1);
    tick();
    req_valid_i = 0;

    // 3: data ahead of a stalled command; 20 stall cycles trip the 16-cycle watchdog
    beats = 0;
    for (int c = 0; c < 20; c++) begin
      app_wdf_rdy_i = c[0];
      if (app_wdf_wren_o && app_wdf_rdy_i) beats++;
      tick();
    end
    app_wdf_rdy_i = 0;
    chk("t3_beats_before_cmd", beats, 8);
    chk("t3_cmd_still_pending", app_en_o, 1'b1);
    app_rdy_i = 1;
    wait_rsp(10);
    app_rdy_i = 0;
    chk("t3_rsp_write", rsp_write_o, 1'b1);
    chk("t3_err_watchdog", err_o, 1'b1);
    rsp_handshake();
    do_reset();

    // 4: read with gaps, response held
    send_read(28'h0001000);
    app_rdy_i = 1;
    for (int k = 0; k < BL; k++) begin
      rd_beat(64'hA0 + 64'(k), k == 7);
      app_rdy_i = 0;
      if (k < 6 && k[0] == 1'b0) tick();
    end
    wait_rsp(4);
    for (int k = 0; k < BL; k++) exp_line[k*W +: W] = 64'hA0 + 64'(k);
    for (int c = 0; c < 5; c++) begin
      chk("t4_rsp_held", rsp_valid_o, 1'b1);
      chk("t4_rdata", rsp_rdata_o, exp_line);
      tick();
    end
    chk("t4_rsp_write", rsp_write_o, 1'b0);
    chk("t4_err", err_o, 1'b0);
    rsp_handshake();
    tick();

    // 5: early end flag on beat 3
    send_read(28'h0002040);
    app_rdy_i = 1;
    for (int k = 0; k < BL; k++) begin
      rd_beat(64'hB0 + 64'(k), k == 3);
      app_rdy_i = 0;
      if (k == 3) chk("t5_err_early_end", err_o, 1'b1);
      if (k == 6) chk("t5_not_done_at_7", rsp_valid_o, 1'b0);
    end
    chk("t5_line_done", rsp_valid_o, 1'b1);
    chk("t5_err_sticky", err_o, 1'b1);
    rsp_handshake();
    do_reset();

    // 6: read with no data returned; watchdog, then reset mid-transfer
    send_read(28'h0003000);
    app_rdy_i = 1;
    first_err = -1;
    for (int n = 1; n <= 40; n++) begin
      tick();
      app_rdy_i = 0;
      if (err_o && first_err < 0) first_err = n;
    end
    chk("t6_watchdog_cycle", first_err, 16);
    chk("t6_still_busy", busy_o, 1'b1);
    ui_reset_i = 1;
    tick();
    chk("t6_ready_in_reset", req_ready_o, 1'b0);
    tick();
    ui_reset_i = 0;
    chk("t6_rst_app_en", app_en_o, 1'b0);
    chk("t6_rst_busy", busy_o, 1'b0);
    chk("t6_rst_err", err_o, 1'b0);
    chk("t6_rst_addr", app_addr_o, '0);
    chk("t6_rst_rsp", rsp_valid_o, 1'b0);
    tick(); tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench did not finish");
  end

endmodule
